// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined IEEE-754 adder/subtractor with valid/ready handshake and tag pass-through.
// Define FPADD_FLAGS_EN to add the registered {NV,OF,UF,NX} o_flags output.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                       s_clk,
    input  logic                       s_rst,
    input  logic                       i_data_valid,
    output logic                       i_ready,
    input  logic                       i_op,
    input  logic [EXP_W+MAN_W:0]       i_data1,
    input  logic [EXP_W+MAN_W:0]       i_data2,
    input  logic [TAG_W-1:0]           i_tag,
    output logic                       o_data_valid,
    input  logic                       o_ready,
    output logic [EXP_W+MAN_W:0]       o_data,
`ifdef FPADD_FLAGS_EN
    output logic [3:0]                 o_flags,
`endif
    output logic [TAG_W-1:0]           o_tag
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int XW   = MAN_W + 4;
    localparam int SW   = MAN_W + 5;
    localparam int LZ_W = $clog2(SW + 1);
    localparam int SH_W = $clog2(MAN_W + 4);
    localparam int EN_W = EXP_W + 2;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [LZ_W-1:0] lzc_f(input logic [SW-1:0] v);
        logic found;
        found = 1'b0;
        lzc_f = {LZ_W{1'b0}};
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    lzc_f = lzc_f + LZ_W'(1);
                end
            end
        end
    endfunction

    logic en_s;
    assign en_s    = o_ready | ~o_data_valid;
    assign i_ready = en_s;

    // Stage 1 combinational: unpack, flush subnormals, special detect, order by magnitude
    logic               a_sign_s, b_sign_s, a_zero_s, b_zero_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s;
    logic [EXP_W-1:0]   a_exp_s, b_exp_s, big_exp_s, small_exp_s;
    logic [MAN_W-1:0]   a_man_s, b_man_s;
    logic [W-2:0]       a_key_s, b_key_s;
    logic [MAN_W:0]     a_sig_s, b_sig_s, big_sig_s, small_sig_s;
    logic               big_sign_s, eff_sub_s, spec_s;
    logic [W-1:0]       spec_val_s;

    always_comb begin
        a_sign_s = i_data1[W-1];
        a_exp_s  = i_data1[W-2:MAN_W];
        a_man_s  = i_data1[MAN_W-1:0];
        b_sign_s = i_data2[W-1] ^ i_op;
        b_exp_s  = i_data2[W-2:MAN_W];
        b_man_s  = i_data2[MAN_W-1:0];
        a_zero_s = (a_exp_s == {EXP_W{1'b0}});
        b_zero_s = (b_exp_s == {EXP_W{1'b0}});
        a_nan_s  = (a_exp_s == {EXP_W{1'b1}}) & (a_man_s != {MAN_W{1'b0}});
        b_nan_s  = (b_exp_s == {EXP_W{1'b1}}) & (b_man_s != {MAN_W{1'b0}});
        a_inf_s  = (a_exp_s == {EXP_W{1'b1}}) & (a_man_s == {MAN_W{1'b0}});
        b_inf_s  = (b_exp_s == {EXP_W{1'b1}}) & (b_man_s == {MAN_W{1'b0}});
        a_key_s  = a_zero_s ? {(W-1){1'b0}} : {a_exp_s, a_man_s};
        b_key_s  = b_zero_s ? {(W-1){1'b0}} : {b_exp_s, b_man_s};
        a_sig_s  = a_zero_s ? {(MAN_W+1){1'b0}} : {1'b1, a_man_s};
        b_sig_s  = b_zero_s ? {(MAN_W+1){1'b0}} : {1'b1, b_man_s};
        eff_sub_s = a_sign_s ^ b_sign_s;
        if (b_key_s > a_key_s) begin
            big_sign_s  = b_sign_s;
            big_exp_s   = b_exp_s;
            small_exp_s = a_exp_s;
            big_sig_s   = b_sig_s;
            small_sig_s = a_sig_s;
        end else begin
            big_sign_s  = a_sign_s;
            big_exp_s   = a_exp_s;
            small_exp_s = b_exp_s;
            big_sig_s   = a_sig_s;
            small_sig_s = b_sig_s;
        end
        spec_s     = 1'b1;
        spec_val_s = {W{1'b0}};
        if (a_nan_s | b_nan_s) begin
            spec_val_s = QNAN;
        end else if (a_inf_s & b_inf_s & eff_sub_s) begin
            spec_val_s = QNAN;
        end else if (a_inf_s) begin
            spec_val_s = {a_sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf_s) begin
            spec_val_s = {b_sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero_s & b_zero_s) begin
            spec_val_s = {a_sign_s & b_sign_s, {(W-1){1'b0}}};
        end else begin
            spec_s = 1'b0;
        end
    end

    logic               v1_r, sign1_r, eff_sub1_r, spec1_r;
    logic [TAG_W-1:0]   tag1_r;
    logic [EXP_W-1:0]   exp1_r, diff1_r;
    logic [MAN_W:0]     big_sig1_r, small_sig1_r;
    logic [W-1:0]       spec_val1_r;

    // Stage 1 register
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            v1_r         <= 1'b0;
            tag1_r       <= {TAG_W{1'b0}};
            sign1_r      <= 1'b0;
            eff_sub1_r   <= 1'b0;
            spec1_r      <= 1'b0;
            spec_val1_r  <= {W{1'b0}};
            exp1_r       <= {EXP_W{1'b0}};
            diff1_r      <= {EXP_W{1'b0}};
            big_sig1_r   <= {(MAN_W+1){1'b0}};
            small_sig1_r <= {(MAN_W+1){1'b0}};
        end else if (en_s) begin
            v1_r         <= i_data_valid;
            tag1_r       <= i_tag;
            sign1_r      <= big_sign_s;
            eff_sub1_r   <= eff_sub_s;
            spec1_r      <= spec_s;
            spec_val1_r  <= spec_val_s;
            exp1_r       <= big_exp_s;
            diff1_r      <= big_exp_s - small_exp_s;
            big_sig1_r   <= big_sig_s;
            small_sig1_r <= small_sig_s;
        end
    end

    // Stage 2 combinational: align smaller operand, folding lost bits into sticky
    logic [SH_W-1:0] shamt_s;
    logic [XW-1:0]   ext_s, shifted_s, lost_mask_s, aligned_s;

    always_comb begin
        if (int'(diff1_r) > MAN_W + 3) begin
            shamt_s = SH_W'(MAN_W + 3);
        end else begin
            shamt_s = SH_W'(diff1_r);
        end
        ext_s       = {small_sig1_r, 3'b000};
        shifted_s   = ext_s >> shamt_s;
        lost_mask_s = ~({XW{1'b1}} << shamt_s);
        aligned_s   = {shifted_s[XW-1:1], shifted_s[0] | (|(ext_s & lost_mask_s))};
    end

    logic               v2_r, sign2_r, eff_sub2_r, spec2_r;
    logic [TAG_W-1:0]   tag2_r;
    logic [EXP_W-1:0]   exp2_r;
    logic [MAN_W:0]     big_sig2_r;
    logic [XW-1:0]      small_al2_r;
    logic [W-1:0]       spec_val2_r;

    // Stage 2 register
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            v2_r        <= 1'b0;
            tag2_r      <= {TAG_W{1'b0}};
            sign2_r     <= 1'b0;
            eff_sub2_r  <= 1'b0;
            spec2_r     <= 1'b0;
            spec_val2_r <= {W{1'b0}};
            exp2_r      <= {EXP_W{1'b0}};
            big_sig2_r  <= {(MAN_W+1){1'b0}};
            small_al2_r <= {XW{1'b0}};
        end else if (en_s) begin
            v2_r        <= v1_r;
            tag2_r      <= tag1_r;
            sign2_r     <= sign1_r;
            eff_sub2_r  <= eff_sub1_r;
            spec2_r     <= spec1_r;
            spec_val2_r <= spec_val1_r;
            exp2_r      <= exp1_r;
            big_sig2_r  <= big_sig1_r;
            small_al2_r <= aligned_s;
        end
    end

    // Stage 3 combinational: magnitude add/subtract (never negative after the swap)
    logic [SW-1:0] big_ext_s, small_ext_s, sum_s;

    always_comb begin
        big_ext_s   = {1'b0, big_sig2_r, 3'b000};
        small_ext_s = {1'b0, small_al2_r};
        if (eff_sub2_r) begin
            sum_s = big_ext_s - small_ext_s;
        end else begin
            sum_s = big_ext_s + small_ext_s;
        end
    end

    logic               v3_r, sign3_r, spec3_r;
    logic [TAG_W-1:0]   tag3_r;
    logic [EXP_W-1:0]   exp3_r;
    logic [SW-1:0]      sum3_r;
    logic [LZ_W-1:0]    lzc3_r;
    logic [W-1:0]       spec_val3_r;

    // Stage 3 register
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            v3_r        <= 1'b0;
            tag3_r      <= {TAG_W{1'b0}};
            sign3_r     <= 1'b0;
            spec3_r     <= 1'b0;
            spec_val3_r <= {W{1'b0}};
            exp3_r      <= {EXP_W{1'b0}};
            sum3_r      <= {SW{1'b0}};
            lzc3_r      <= {LZ_W{1'b0}};
        end else if (en_s) begin
            v3_r        <= v2_r;
            tag3_r      <= tag2_r;
            sign3_r     <= sign2_r;
            spec3_r     <= spec2_r;
            spec_val3_r <= spec_val2_r;
            exp3_r      <= exp2_r;
            sum3_r      <= sum_s;
            lzc3_r      <= lzc_f(sum_s);
        end
    end

    // Stage 4 combinational: normalise so the leading one sits at the top bit, round RNE, pack
    logic [SW-1:0]    norm_s;
    logic [EN_W-1:0]  exp_n_s, exp_r_s;
    logic [MAN_W+1:0] mant_r_s;
    logic [MAN_W-1:0] man_out_s;
    logic             guard_s, round_s, sticky_s, round_up_s, zero_s, uf_s, of_s;
    logic [W-1:0]     res_s;

    always_comb begin
        norm_s     = sum3_r << lzc3_r;
        exp_n_s    = {2'b00, exp3_r} + EN_W'(1) - EN_W'(lzc3_r);
        guard_s    = norm_s[3];
        round_s    = norm_s[2];
        sticky_s   = |norm_s[1:0];
        round_up_s = guard_s & (round_s | sticky_s | norm_s[4]);
        mant_r_s   = {1'b0, norm_s[SW-1:4]} + {{(MAN_W+1){1'b0}}, round_up_s};
        exp_r_s    = exp_n_s + {{(EN_W-1){1'b0}}, mant_r_s[MAN_W+1]};
        if (mant_r_s[MAN_W+1]) begin
            man_out_s = mant_r_s[MAN_W:1];
        end else begin
            man_out_s = mant_r_s[MAN_W-1:0];
        end
        zero_s = (sum3_r == {SW{1'b0}});
        uf_s   = exp_n_s[EN_W-1] | (exp_n_s == {EN_W{1'b0}});
        of_s   = ~uf_s & (exp_r_s >= {2'b00, {EXP_W{1'b1}}});
        if (spec3_r) begin
            res_s = spec_val3_r;
        end else if (zero_s) begin
            res_s = {W{1'b0}};
        end else if (uf_s) begin
            res_s = {sign3_r, {(W-1){1'b0}}};
        end else if (of_s) begin
            res_s = {sign3_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            res_s = {sign3_r, exp_r_s[EXP_W-1:0], man_out_s};
        end
    end

`ifdef FPADD_FLAGS_EN
    logic       nv1_r, nv2_r, nv3_r;
    logic [3:0] flags_s;

    // Invalid-operation marker travelling alongside the special-case result
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            nv1_r <= 1'b0;
            nv2_r <= 1'b0;
            nv3_r <= 1'b0;
        end else if (en_s) begin
            nv1_r <= a_inf_s & b_inf_s & eff_sub_s;
            nv2_r <= nv1_r;
            nv3_r <= nv2_r;
        end
    end

    // Exception flags for the result currently in stage 4
    always_comb begin
        if (spec3_r) begin
            flags_s = {nv3_r, 3'b000};
        end else if (zero_s) begin
            flags_s = 4'b0000;
        end else if (uf_s) begin
            flags_s = 4'b0011;
        end else if (of_s) begin
            flags_s = 4'b0101;
        end else begin
            flags_s = {3'b000, guard_s | round_s | sticky_s};
        end
    end
`endif

    // Output register, held while downstream stalls
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            o_data_valid <= 1'b0;
            o_data       <= {W{1'b0}};
            o_tag        <= {TAG_W{1'b0}};
`ifdef FPADD_FLAGS_EN
            o_flags      <= 4'b0000;
`endif
        end else if (en_s) begin
            o_data_valid <= v3_r;
            o_data       <= res_s;
            o_tag        <= tag3_r;
`ifdef FPADD_FLAGS_EN
            o_flags      <= flags_s;
`endif
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: fp32 instance with backpressure/reset, plus an fp16 instance.
module tb_fp_addsub_pipe;
    typedef struct { logic op; logic [31:0] a; logic [31:0] b; logic [31:0] r; logic [3:0] f; } vec_t;
    typedef struct { logic [31:0] data; logic [3:0] tag; logic [3:0] flags; } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_data_valid, i_ready, i_op, o_data_valid, o_ready;
    logic [31:0] i_data1, i_data2, o_data;
    logic [3:0]  i_tag, o_tag;
    logic        h_i_data_valid, h_i_ready, h_i_op, h_o_data_valid;
    logic        h_o_ready = 1'b1;
    logic [15:0] h_i_data1, h_i_data2, h_o_data;
    logic [3:0]  h_i_tag, h_o_tag;
`ifdef FPADD_FLAGS_EN
    logic [3:0]  o_flags, h_o_flags;
`endif

    exp_t  sb[$];
    exp_t  hsb[$];
    exp_t  mon_e, hmon_e;
    vec_t  vt[16];
    int    n_vec = 0;
    int    n_fail = 0;
    logic        stall_seen = 1'b0;
    logic [31:0] held_data;
    logic [3:0]  held_tag;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut32 (
        .s_clk(clk), .s_rst(rst),
        .i_data_valid(i_data_valid), .i_ready(i_ready), .i_op(i_op),
        .i_data1(i_data1), .i_data2(i_data2), .i_tag(i_tag),
        .o_data_valid(o_data_valid), .o_ready(o_ready), .o_data(o_data),
`ifdef FPADD_FLAGS_EN
        .o_flags(o_flags),
`endif
        .o_tag(o_tag)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut16 (
        .s_clk(clk), .s_rst(rst),
        .i_data_valid(h_i_data_valid), .i_ready(h_i_ready), .i_op(h_i_op),
        .i_data1(h_i_data1), .i_data2(h_i_data2), .i_tag(h_i_tag),
        .o_data_valid(h_o_data_valid), .o_ready(h_o_ready), .o_data(h_o_data),
`ifdef FPADD_FLAGS_EN
        .o_flags(h_o_flags),
`endif
        .o_tag(h_o_tag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // fp32 monitor: compares each accepted result with the scoreboard head, and checks hold during stalls
    always @(negedge clk) begin
        if (!rst && o_data_valid) begin
            if (stall_seen) begin
                check("hold_data", o_data, held_data);
                check("hold_tag", {28'h0, o_tag}, {28'h0, held_tag});
            end
            if (o_ready) begin
                stall_seen = 1'b0;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %h tag %0d, expected none", o_data, o_tag);
                end else begin
                    mon_e = sb.pop_front();
                    check("result_data", o_data, mon_e.data);
                    check("result_tag", {28'h0, o_tag}, {28'h0, mon_e.tag});
`ifdef FPADD_FLAGS_EN
                    check("result_flags", {28'h0, o_flags}, {28'h0, mon_e.flags});
`endif
                end
            end else begin
                stall_seen = 1'b1;
                held_data  = o_data;
                held_tag   = o_tag;
            end
        end else begin
            stall_seen = 1'b0;
        end
    end

    // fp16 monitor
    always @(negedge clk) begin
        if (!rst && h_o_data_valid) begin
            if (hsb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL h_unexpected_result: got %h, expected none", h_o_data);
            end else begin
                hmon_e = hsb.pop_front();
                check("h_result_data", {16'h0, h_o_data}, hmon_e.data);
                check("h_result_tag", {28'h0, h_o_tag}, {28'h0, hmon_e.tag});
`ifdef FPADD_FLAGS_EN
                check("h_result_flags", {28'h0, h_o_flags}, {28'h0, hmon_e.flags});
`endif
            end
        end
    end

    task automatic send(input vec_t v, input logic [3:0] tag);
        int   waited = 0;
        exp_t e;
        i_data_valid = 1'b1;
        i_op    = v.op;
        i_data1 = v.a;
        i_data2 = v.b;
        i_tag   = tag;
        @(negedge clk);
        while (!i_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!i_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: i_ready got 0, expected 1 within 50 cycles");
        end else begin
            e.data  = v.r;
            e.tag   = tag;
            e.flags = v.f;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_latency(input string name);
        int seen = 0;
        for (int k = 1; k <= 6; k++) begin
            if (o_data_valid && seen == 0) seen = k;
            @(posedge clk);
            #1;
        end
        check(name, 32'(seen), 32'd4);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || hsb.size() != 0) && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_pending", 32'(sb.size() + hsb.size()), 32'd0);
    endtask

    task automatic h_send(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] tag, input logic [15:0] r, input logic [3:0] f);
        exp_t e;
        h_i_data_valid = 1'b1;
        h_i_op    = op;
        h_i_data1 = a;
        h_i_data2 = b;
        h_i_tag   = tag;
        @(negedge clk);
        check("h_in_ready", {31'h0, h_i_ready}, 32'd1);
        e.data  = {16'h0, r};
        e.tag   = tag;
        e.flags = f;
        hsb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int post_cnt;
        vt[0]  = '{1'b0, 32'h3FE00000, 32'h40280000, 32'h408C0000, 4'b0000};
        vt[1]  = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001};
        vt[2]  = '{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001};
        vt[3]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000};
        vt[4]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000};
        vt[5]  = '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000};
        vt[6]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101};
        vt[7]  = '{1'b1, 32'h3FE00000, 32'h40280000, 32'hBF600000, 4'b0000};
        vt[8]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000};
        vt[9]  = '{1'b1, 32'h00800000, 32'h00800001, 32'h80000000, 4'b0011};
        vt[10] = '{1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000};
        vt[11] = '{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000};
        vt[12] = '{1'b1, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 4'b0000};
        vt[13] = '{1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'b0001};
        vt[14] = '{1'b0, 32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 4'b0101};
        vt[15] = '{1'b1, 32'h3F800000, 32'hBF800000, 32'h40000000, 4'b0000};
        i_data_valid = 1'b0; i_op = 1'b0; i_data1 = 32'h0; i_data2 = 32'h0; i_tag = 4'h0;
        h_i_data_valid = 1'b0; h_i_op = 1'b0; h_i_data1 = 16'h0; h_i_data2 = 16'h0; h_i_tag = 4'h0;
        o_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", {31'h0, o_data_valid}, 32'd0);
        check("reset_data", o_data, 32'h0);
        check("reset_tag", {28'h0, o_tag}, 32'h0);
`ifdef FPADD_FLAGS_EN
        check("reset_flags", {28'h0, o_flags}, 32'h0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single op: latency and tag
        send(vt[0], 4'd5);
        i_data_valid = 1'b0;
        check_latency("latency_first");
        drain();

        // full table back to back with a 3-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 16; i++) send(vt[i], 4'(i));
                i_data_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                o_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'h0, i_ready}, 32'd0);
                    check("stall_out_valid", {31'h0, o_data_valid}, 32'd1);
                    @(posedge clk);
                    #1;
                end
                o_ready = 1'b1;
            end
        join
        drain();

        // reset with ops in flight
        for (int i = 0; i < 3; i++) send(vt[i + 1], 4'(8 + i));
        i_data_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_valid", {31'h0, o_data_valid}, 32'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("reset_immediate_valid", {31'h0, o_data_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        post_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_data_valid) post_cnt++;
        end
        check("post_reset_quiet", 32'(post_cnt), 32'd0);
        @(posedge clk);
        #1;
        send(vt[13], 4'd3);
        i_data_valid = 1'b0;
        check_latency("latency_after_reset");
        drain();

        // half precision instance
        h_send(1'b0, 16'h3C00, 16'h3C00, 4'd1, 16'h4000, 4'b0000);
        h_send(1'b0, 16'h7BFF, 16'h7BFF, 4'd2, 16'h7C00, 4'b0101);
        h_send(1'b1, 16'h3C00, 16'h3800, 4'd3, 16'h3800, 4'b0000);
        h_i_data_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
